mem_arb: RTL and testbench

MEM_ARB -- requirements
Module: mem_arb

---
 rtl/cpu_pkg.sv | 27 ++
 rtl/mem_arb.sv | 160 ++++++++++++++++
 tb/tb_mem_arb.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: memory arbiter FSM states, default bus widths,
// requester encoding and the fetch byte-enable masks.
package cpu_pkg;

    localparam int unsigned AwDefault = 64;
    localparam int unsigned DwDefault = 64;

    // A fetch reads one 32-bit word out of a 64-bit memory beat.
    localparam logic [7:0] FetchBytesLo = 8'h0F;
    localparam logic [7:0] FetchBytesHi = 8'hF0;

    // Owner and last-grant encoding; the reset value 0 means load/store.
    localparam logic OwnerLs = 1'b0;
    localparam logic OwnerIf = 1'b1;

    typedef enum logic [1:0] {
        StIdle,
        StAddr,
        StData
    } arb_state_e;

    // Byte mask selecting the instruction word addressed by bit 2.
    function automatic logic [7:0] fetch_bytes(input logic addr_bit2);
        return addr_bit2 ? FetchBytesHi : FetchBytesLo;
    endfunction

endpackage

// File: rtl/mem_arb.sv
// Two-requester memory arbiter: instruction fetch and load/store share one
// memory port with at most one transaction in flight (IDLE -> ADDR -> DATA).
// Build option MEM_ARB_RR_EN: round-robin arbitration on contention; when
// undefined, load/store has fixed priority over fetch.
module mem_arb
    import cpu_pkg::*;
#(
    parameter int unsigned AW = AwDefault,
    parameter int unsigned DW = DwDefault
) (
    input  logic          clk,
    input  logic          rstn,

    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_rvalid,
    output logic [31:0]   if_rdata,

    input  logic          ls_req,
    input  logic          ls_wr,
    input  logic [7:0]    ls_bytes,
    input  logic [AW-1:0] ls_addr,
    input  logic [DW-1:0] ls_wdata,
    output logic          ls_rvalid,
    output logic [DW-1:0] ls_rdata,

    output logic          mem_req,
    output logic          mem_wr,
    output logic [7:0]    mem_bytes,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_gnt,
    input  logic          mem_rvalid,
    input  logic [DW-1:0] mem_rdata
);

    arb_state_e    state_q, state_d;
    logic          wr_q, wr_d;
    logic [7:0]    bytes_q, bytes_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          owner_q, owner_d;
    logic          any_req;
    logic          pick_ls;
    logic          rsp_hit;

    assign any_req = ls_req | if_req;

`ifdef MEM_ARB_RR_EN
    logic last_q, last_d;

    // Winner selection: on contention the requester not granted last wins.
    always_comb begin
        pick_ls = ls_req;
        if (ls_req && if_req) begin
            pick_ls = (last_q == OwnerIf);
        end
    end

    // Last-grant tracking, updated on every grant including uncontended ones.
    always_comb begin
        last_d = last_q;
        if (state_q == StIdle && any_req) begin
            last_d = pick_ls ? OwnerLs : OwnerIf;
        end
    end

    // Last-grant register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_q <= OwnerLs;
        end else begin
            last_q <= last_d;
        end
    end
`else
    // Winner selection: load/store always beats fetch.
    assign pick_ls = ls_req;
`endif

    // Next-state logic and capture of the winning request in IDLE.
    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        bytes_d = bytes_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        owner_d = owner_q;
        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    state_d = StAddr;
                    if (pick_ls) begin
                        owner_d = OwnerLs;
                        wr_d    = ls_wr;
                        bytes_d = ls_bytes;
                        addr_d  = ls_addr;
                        wdata_d = ls_wdata;
                    end else begin
                        owner_d = OwnerIf;
                        wr_d    = 1'b0;
                        bytes_d = fetch_bytes(if_addr[2]);
                        addr_d  = if_addr;
                        wdata_d = '0;
                    end
                end
            end
            StAddr: begin
                // A response arriving with the grant is not a response.
                if (mem_gnt) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (mem_rvalid) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and latched request registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
            wr_q    <= 1'b0;
            bytes_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            owner_q <= OwnerLs;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            bytes_q <= bytes_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            owner_q <= owner_d;
        end
    end

    // Memory port driven straight from the latched request.
    always_comb begin
        mem_req   = (state_q == StAddr);
        mem_wr    = wr_q;
        mem_bytes = bytes_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
    end

    // Response routing to the owner; read data passes through combinationally.
    always_comb begin
        rsp_hit   = (state_q == StData) && mem_rvalid;
        if_rvalid = rsp_hit && (owner_q == OwnerIf);
        ls_rvalid = rsp_hit && (owner_q == OwnerLs);
        ls_rdata  = mem_rdata;
        if_rdata  = addr_q[2] ? mem_rdata[63:32] : mem_rdata[31:0];
    end

endmodule

// File: tb/tb_mem_arb.sv
// Scoreboard bench for mem_arb: expected memory transactions are queued when
// requests are raised and checked as the arbiter presents them.
module tb_mem_arb;

    localparam int unsigned AW = 64;
    localparam int unsigned DW = 64;

    logic          clk;
    logic          rstn;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_rvalid;
    logic [31:0]   if_rdata;
    logic          ls_req;
    logic          ls_wr;
    logic [7:0]    ls_bytes;
    logic [AW-1:0] ls_addr;
    logic [DW-1:0] ls_wdata;
    logic          ls_rvalid;
    logic [DW-1:0] ls_rdata;
    logic          mem_req;
    logic          mem_wr;
    logic [7:0]    mem_bytes;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_gnt;
    logic          mem_rvalid;
    logic [DW-1:0] mem_rdata;

    typedef struct {
        bit          is_ls;
        bit          wr;
        logic [7:0]  bytes;
        logic [63:0] addr;
        logic [63:0] wdata;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks;
    int   n_errors;

    mem_arb #(
        .AW(AW),
        .DW(DW)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .ls_req    (ls_req),
        .ls_wr     (ls_wr),
        .ls_bytes  (ls_bytes),
        .ls_addr   (ls_addr),
        .ls_wdata  (ls_wdata),
        .ls_rvalid (ls_rvalid),
        .ls_rdata  (ls_rdata),
        .mem_req   (mem_req),
        .mem_wr    (mem_wr),
        .mem_bytes (mem_bytes),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_gnt   (mem_gnt),
        .mem_rvalid(mem_rvalid),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Expected entries for each requester; fetch masks come from address bit 2.
    task automatic push_if(input logic [63:0] addr);
        exp_t e;
        e.is_ls = 1'b0;
        e.wr    = 1'b0;
        e.bytes = addr[2] ? 8'hF0 : 8'h0F;
        e.addr  = addr;
        e.wdata = 64'd0;
        sb_q.push_back(e);
    endtask

    task automatic push_ls(input bit wr, input logic [7:0] bytes, input logic [63:0] addr,
                           input logic [63:0] wdata);
        exp_t e;
        e.is_ls = 1'b1;
        e.wr    = wr;
        e.bytes = bytes;
        e.addr  = addr;
        e.wdata = wdata;
        sb_q.push_back(e);
    endtask

    task automatic drive_if(input logic [63:0] addr);
        if_req  = 1'b1;
        if_addr = addr;
    endtask

    task automatic drive_ls(input bit wr, input logic [7:0] bytes, input logic [63:0] addr,
                            input logic [63:0] wdata);
        ls_req   = 1'b1;
        ls_wr    = wr;
        ls_bytes = bytes;
        ls_addr  = addr;
        ls_wdata = wdata;
    endtask

    // Bounded wait, sampled on falling edges, for the arbiter to raise mem_req.
    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (mem_req) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("mem_req_timeout", 64'd0, 64'd1);
    endtask

    // Memory model for one transaction: grant after gnt_dly stall cycles,
    // respond on the following cycle, and compare against the scoreboard.
    task automatic serve(input int gnt_dly, input bit spur, input bit garble, input bit gnt_rv,
                         input logic [63:0] rdata);
        exp_t e;
        bit   ok;
        logic [31:0] exp_word;
        wait_req(ok);
        if (!ok) return;
        if (sb_q.size() == 0) begin
            check("sb_empty", 64'd0, 64'd1);
            return;
        end
        e = sb_q.pop_front();
        check("mem_wr", 64'(mem_wr), 64'(e.wr));
        check("mem_bytes", 64'(mem_bytes), 64'(e.bytes));
        check("mem_addr", mem_addr, e.addr);
        if (e.wr) check("mem_wdata", mem_wdata, e.wdata);
        for (int i = 0; i < gnt_dly; i++) begin
            if (garble) ls_addr = {$urandom(), $urandom()};
            if (spur && i == 0) begin
                mem_rvalid = 1'b1;
                #1;
                check("spur_addr_ls_rv", 64'(ls_rvalid), 64'd0);
                check("spur_addr_if_rv", 64'(if_rvalid), 64'd0);
            end
            @(negedge clk);
            mem_rvalid = 1'b0;
            check("stall_req", 64'(mem_req), 64'd1);
            check("stall_addr", mem_addr, e.addr);
            check("stall_bytes", 64'(mem_bytes), 64'(e.bytes));
            check("stall_wr", 64'(mem_wr), 64'(e.wr));
        end
        mem_gnt    = 1'b1;
        mem_rvalid = gnt_rv;
        mem_rdata  = rdata;
        #1;
        check("gnt_cycle_rv", 64'(ls_rvalid | if_rvalid), 64'd0);
        @(negedge clk);
        mem_gnt = 1'b0;
        check("data_req_low", 64'(mem_req), 64'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        #1;
        check("ls_rvalid", 64'(ls_rvalid), 64'(e.is_ls));
        check("if_rvalid", 64'(if_rvalid), 64'(!e.is_ls));
        exp_word = e.addr[2] ? rdata[63:32] : rdata[31:0];
        if (e.is_ls) begin
            check("ls_rdata", ls_rdata, rdata);
            ls_req = 1'b0;
        end else begin
            check("if_rdata", 64'(if_rdata), 64'(exp_word));
            if_req = 1'b0;
        end
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        check("rv_one_cycle", 64'(ls_rvalid | if_rvalid), 64'd0);
        check("idle_req_low", 64'(mem_req), 64'd0);
    endtask

    initial begin
        bit ok;
        n_checks   = 0;
        n_errors   = 0;
        rstn       = 1'b0;
        if_req     = 1'b0;
        if_addr    = '0;
        ls_req     = 1'b0;
        ls_wr      = 1'b0;
        ls_bytes   = '0;
        ls_addr    = '0;
        ls_wdata   = '0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        #1;
        check("rst_mem_req", 64'(mem_req), 64'd0);
        check("rst_mem_wr", 64'(mem_wr), 64'd0);
        check("rst_if_rvalid", 64'(if_rvalid), 64'd0);
        check("rst_ls_rvalid", 64'(ls_rvalid), 64'd0);
        check("rst_mem_bytes", 64'(mem_bytes), 64'd0);
        check("rst_mem_addr", mem_addr, 64'd0);
        check("rst_mem_wdata", mem_wdata, 64'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // Spurious response while idle.
        mem_rvalid = 1'b1;
        #1;
        check("spur_idle_ls_rv", 64'(ls_rvalid), 64'd0);
        check("spur_idle_if_rv", 64'(if_rvalid), 64'd0);
        @(negedge clk);
        mem_rvalid = 1'b0;
        check("spur_idle_req", 64'(mem_req), 64'd0);

        // Upper-word fetch.
        drive_if(64'h0000_0000_8000_0004);
        push_if(64'h0000_0000_8000_0004);
        serve(0, 1'b0, 1'b0, 1'b0, 64'h0010_0073_0000_0013);

        // Lower-word fetch with a stall and a spurious response in ADDR.
        drive_if(64'h0000_0000_8000_0000);
        push_if(64'h0000_0000_8000_0000);
        serve(2, 1'b1, 1'b0, 1'b0, 64'hCAFE_F00D_1234_5678);

        // Load where the grant and a response coincide.
        drive_ls(1'b0, 8'h0F, 64'h0000_0000_0000_1000, 64'h0);
        push_ls(1'b0, 8'h0F, 64'h0000_0000_0000_1000, 64'h0);
        serve(0, 1'b0, 1'b0, 1'b1, 64'h1122_3344_5566_7788);

        // Contention: store and fetch rise together.
        drive_ls(1'b1, 8'hFF, 64'h0000_0000_0000_2000, 64'h0000_0000_DEAD_BEEF);
        drive_if(64'h0000_0000_8000_0008);
`ifdef MEM_ARB_RR_EN
        push_if(64'h0000_0000_8000_0008);
        push_ls(1'b1, 8'hFF, 64'h0000_0000_0000_2000, 64'h0000_0000_DEAD_BEEF);
`else
        push_ls(1'b1, 8'hFF, 64'h0000_0000_0000_2000, 64'h0000_0000_DEAD_BEEF);
        push_if(64'h0000_0000_8000_0008);
`endif
        serve(0, 1'b0, 1'b0, 1'b0, 64'h0);
        serve(0, 1'b0, 1'b0, 1'b0, 64'hAAAA_BBBB_CCCC_DDDD);

        // Five-cycle grant stall while the load/store address wanders.
        drive_ls(1'b1, 8'h3C, 64'h0000_0000_0000_3000, 64'h0123_4567_89AB_CDEF);
        push_ls(1'b1, 8'h3C, 64'h0000_0000_0000_3000, 64'h0123_4567_89AB_CDEF);
        serve(5, 1'b0, 1'b1, 1'b0, 64'h0);

        // Reset in DATA abandons the fetch.
        drive_if(64'h0000_0000_8000_0010);
        wait_req(ok);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt    = 1'b0;
        rstn       = 1'b0;
        mem_rvalid = 1'b1;
        #1;
        check("rst_data_req", 64'(mem_req), 64'd0);
        check("rst_data_if_rv", 64'(if_rvalid), 64'd0);
        check("rst_data_ls_rv", 64'(ls_rvalid), 64'd0);
        if_req = 1'b0;
        @(negedge clk);
        mem_rvalid = 1'b0;
        rstn       = 1'b1;
        @(negedge clk);

        // Normal load after the abandoned transaction.
        drive_ls(1'b0, 8'hFF, 64'h0000_0000_0000_4008, 64'h0);
        push_ls(1'b0, 8'hFF, 64'h0000_0000_0000_4008, 64'h0);
        serve(1, 1'b0, 1'b0, 1'b0, 64'h5555_6666_7777_8888);

        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
